// File: rtl/hypot_pkg.sv
// Shared types and width helpers for the iterative hypotenuse block.
package hypot_pkg;

   typedef enum logic [1:0] {IDLE, SQ, CALC, DONE} state_t;

   // Widest operand abs_w accepts; callers sign-extend to this width first.
   localparam int MAXW = 32;

   function automatic int sumw(input int w);
      return 2*w + 1;
   endfunction

   function automatic int rw(input int w);
      return w + 1;
   endfunction

   function automatic int cw(input int w);
      return $clog2(w + 1);
   endfunction

   function automatic logic [MAXW-1:0] abs_w(input logic [MAXW-1:0] v);
      return v[MAXW-1] ? (~v + 1'b1) : v;
   endfunction

endpackage

// File: rtl/hypot_isqrt_step.sv
// One restoring square-root iteration: folds the next two radicand bits into rem/root.
module hypot_isqrt_step #(
   parameter int RW = 9
) (
   input  logic [RW:0]   rem,
   input  logic [RW-1:0] root,
   input  logic [1:0]    pair,
   output logic [RW:0]   rem_next,
   output logic [RW-1:0] root_next
);

   localparam int TW = RW + 3;

   logic [TW-1:0] cand;
   logic [TW-1:0] sub;
   logic [TW-1:0] trial;

   always_comb begin
      cand  = {rem, pair};
      sub   = TW'({root, 2'b01});
      trial = cand - sub;
      // Remainder never exceeds 2*root, so RW+1 bits always hold it.
      if (cand >= sub) begin
         rem_next  = (RW+1)'(trial);
         root_next = RW'({root, 1'b1});
      end else begin
         rem_next  = (RW+1)'(cand);
         root_next = RW'({root, 1'b0});
      end
   end

endmodule

// File: rtl/hypot_iter.sv
// Handshaked sqrt(x^2 + y^2), one root bit per cycle, optional round-to-nearest.
module hypot_iter
   import hypot_pkg::*;
#(
   parameter int W      = 8,
   parameter bit SIGNED = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_x,
   input  logic [W-1:0] in_y,
   input  logic         in_round,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W:0]   out_r,
   output logic         out_exact,
   output logic         busy
);

   localparam int SW   = sumw(W);
   localparam int RW   = rw(W);
   localparam int CW   = cw(W);
   localparam int PW   = 2 * RW;   // radicand padded to a whole number of bit pairs
   localparam int REMW = RW + 1;

   state_t          state_q, state_d;
   logic [W-1:0]    ax_q, ax_d, ay_q, ay_d;
   logic            rnd_q, rnd_d;
   logic [PW-1:0]   sum_q, sum_d;
   logic [RW-1:0]   root_q, root_d;
   logic [REMW-1:0] rem_q, rem_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [RW-1:0]   out_r_q, out_r_d;
   logic            exact_q, exact_d;

   logic [MAXW-1:0] x_ext, y_ext;
   logic [W-1:0]    x_mag, y_mag;
   logic [SW-1:0]   sq_sum;
   logic [REMW-1:0] step_rem;
   logic [RW-1:0]   step_root;
   logic            round_up;

   always_comb begin
      if (SIGNED) begin
         x_ext = abs_w(MAXW'($signed(in_x)));
         y_ext = abs_w(MAXW'($signed(in_y)));
      end else begin
         x_ext = MAXW'(in_x);
         y_ext = MAXW'(in_y);
      end
      x_mag = W'(x_ext);
      y_mag = W'(y_ext);
   end

   assign sq_sum = SW'(ax_q) * SW'(ax_q) + SW'(ay_q) * SW'(ay_q);

   hypot_isqrt_step #(.RW(RW)) u_step (
      .rem       (rem_q),
      .root      (root_q),
      .pair      (sum_q[PW-1 -: 2]),
      .rem_next  (step_rem),
      .root_next (step_root)
   );

   // (r + 0.5)^2 = r^2 + r + 0.25, so round up exactly when rem > r.
   assign round_up = rnd_q && (step_rem > REMW'(step_root));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ax_q    <= '0;
         ay_q    <= '0;
         rnd_q   <= 1'b0;
         sum_q   <= '0;
         root_q  <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         out_r_q <= '0;
         exact_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ax_q    <= ax_d;
         ay_q    <= ay_d;
         rnd_q   <= rnd_d;
         sum_q   <= sum_d;
         root_q  <= root_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         out_r_q <= out_r_d;
         exact_q <= exact_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ax_d    = ax_q;
      ay_d    = ay_q;
      rnd_d   = rnd_q;
      sum_d   = sum_q;
      root_d  = root_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      out_r_d = out_r_q;
      exact_d = exact_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               ax_d    = x_mag;
               ay_d    = y_mag;
               rnd_d   = in_round;
               state_d = SQ;
            end
         end
         SQ: begin
            sum_d   = PW'(sq_sum);
            root_d  = '0;
            rem_d   = '0;
            cnt_d   = CW'(W);
            state_d = CALC;
         end
         CALC: begin
            sum_d  = sum_q << 2;
            root_d = step_root;
            rem_d  = step_rem;
            cnt_d  = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               out_r_d = step_root + RW'(round_up);
               exact_d = (step_rem == '0);
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign out_valid = (state_q == DONE);
   assign out_r     = out_r_q;
   assign out_exact = exact_q;

endmodule

// File: tb/tb_hypot_iter.sv
// Randomised and directed bench: unsigned and signed instances against an arithmetic reference.
module tb_hypot_iter;

   logic       clk;
   logic       rst;
   logic [7:0] in_x, in_y;
   logic       in_round;
   logic [1:0] iv, ir, ov, ordy, bsy, oex;
   logic [8:0] r0, r1;

   int n_chk = 0;
   int n_err = 0;

   hypot_iter #(.W(8), .SIGNED(1'b0)) u_uns (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_x(in_x), .in_y(in_y),
      .in_round(in_round), .out_valid(ov[0]), .out_ready(ordy[0]), .out_r(r0),
      .out_exact(oex[0]), .busy(bsy[0])
   );

   hypot_iter #(.W(8), .SIGNED(1'b1)) u_sgn (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_x(in_x), .in_y(in_y),
      .in_round(in_round), .out_valid(ov[1]), .out_ready(ordy[1]), .out_r(r1),
      .out_exact(oex[1]), .busy(bsy[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [8:0] rsel(input int sel);
      return (sel == 0) ? r0 : r1;
   endfunction

   // Reference: magnitude from plain integer arithmetic.
   task automatic model(input int sel, input logic [7:0] x, input logic [7:0] y, input bit rnd,
                        output int er, output bit ee);
      int ax, ay, s, r;
      ax = (sel == 1 && x[7]) ? 256 - int'(x) : int'(x);
      ay = (sel == 1 && y[7]) ? 256 - int'(y) : int'(y);
      s  = ax*ax + ay*ay;
      r  = 0;
      while ((r+1)*(r+1) <= s) r++;
      ee = (r*r == s);
      er = (rnd && (s - r*r > r)) ? r + 1 : r;
   endtask

   task automatic run(input int sel, input logic [7:0] x, input logic [7:0] y, input bit rnd,
                      input int hold);
      int er, lat;
      bit ee, rdy_bad;
      logic [8:0] held_r;
      logic held_e;
      model(sel, x, y, rnd, er, ee);
      @(negedge clk);
      in_x = x; in_y = y; in_round = rnd;
      chk("rdy_idle", 32'(ir[sel]), 32'd1);
      iv[sel] = 1'b1;
      @(negedge clk);
      iv[sel] = 1'b0;
      in_x = 8'($urandom); in_y = 8'($urandom); in_round = 1'($urandom);
      lat = 0; rdy_bad = 0;
      while (!ov[sel] && lat < 40) begin
         if (ir[sel]) rdy_bad = 1;
         @(negedge clk);
         lat++;
      end
      chk("latency", 32'(lat), 32'd10);
      chk("rdy_low_busy", 32'(rdy_bad), 32'd0);
      chk("out_r", 32'(rsel(sel)), 32'(er));
      chk("out_exact", 32'(oex[sel]), 32'(ee));
      if (hold > 0) begin
         held_r = rsel(sel); held_e = oex[sel];
         iv[sel] = 1'b1;
         rdy_bad = 0;
         repeat (hold) begin
            @(negedge clk);
            in_x = 8'($urandom); in_y = 8'($urandom);
            if (rsel(sel) !== held_r || oex[sel] !== held_e || !ov[sel] || ir[sel]) rdy_bad = 1;
         end
         chk("bp_stable", 32'(rdy_bad), 32'd0);
      end
      ordy[sel] = 1'b1;
      @(negedge clk);
      ordy[sel] = 1'b0;
      chk("handoff_valid", 32'(ov[sel]), 32'd0);
      chk("no_accept_done", 32'(bsy[sel]), 32'd0);
      iv[sel] = 1'b0;
   endtask

   initial begin
      int lat;
      bit seen;
      rst = 1'b1; iv = '0; ordy = '0; in_x = '0; in_y = '0; in_round = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_out_r", 32'(r0), 32'd0);
      chk("rst_exact", 32'(oex[0]), 32'd0);
      chk("rst_ready", 32'(ir), 32'd3);
      chk("rst_valid", 32'(ov), 32'd0);
      chk("rst_busy", 32'(bsy), 32'd0);
      iv[0] = 1'b1; in_x = 8'd3; in_y = 8'd4;
      @(negedge clk);
      chk("rst_blocks_accept", 32'(bsy[0]), 32'd0);
      rst = 1'b0; iv[0] = 1'b0;

      run(0, 8'd3,   8'd4,   1'b0, 0);
      run(0, 8'd5,   8'd12,  1'b0, 0);
      run(0, 8'd0,   8'd10,  1'b0, 0);
      run(0, 8'd10,  8'd0,   1'b0, 0);
      run(0, 8'd0,   8'd0,   1'b0, 0);
      run(0, 8'd255, 8'd255, 1'b0, 0);
      run(0, 8'd255, 8'd255, 1'b1, 0);
      run(0, 8'd1,   8'd1,   1'b1, 0);
      run(1, 8'hF9,  8'd24,  1'b0, 0);
      run(1, 8'h80,  8'd0,   1'b0, 0);
      run(1, 8'h80,  8'h80,  1'b1, 2);
      run(0, 8'd7,   8'd9,   1'b1, 20);

      // Reset four cycles into the computation discards the request.
      @(negedge clk);
      in_x = 8'd3; in_y = 8'd4; in_round = 1'b0; iv[0] = 1'b1;
      @(negedge clk);
      iv[0] = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_mid_ready", 32'(ir[0]), 32'd1);
      chk("rst_mid_busy", 32'(bsy[0]), 32'd0);
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         if (ov[0]) seen = 1;
         @(negedge clk);
      end
      chk("rst_mid_no_out", 32'(seen), 32'd0);
      run(0, 8'd3, 8'd4, 1'b0, 0);

      for (int i = 0; i < 60; i++)
         run(i % 2, 8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

      lat = 0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
